// File: rtl/m2_scheduler.sv
// Milestone-2 block sequencer: walks every 8x8 block through fetch S', compute T,
// compute S and write S, overlapping CS(k)+FS(k+1) and CT(k+1)+WS(k), and owns the SRAM port.
module m2_scheduler #(
    parameter int NUM_BLOCKS = 2400,
    parameter int BLK_W      = 12
) (
    input  logic             CLOCK_50_I,
    input  logic             Reset,
    input  logic             M2_start,
    output logic             M2_done,
    output logic             FS_start,
    output logic             CT_start,
    output logic             CS_start,
    output logic             WS_start,
    input  logic             FS_done,
    input  logic             CT_done,
    input  logic             CS_done,
    input  logic             WS_done,
    input  logic [17:0]      FS_SRAM_address,
    input  logic [17:0]      WS_SRAM_address,
    input  logic [15:0]      WS_SRAM_write_data,
    input  logic             WS_SRAM_we_n,
    output logic [17:0]      SRAM_address,
    output logic [15:0]      SRAM_write_data,
    output logic             SRAM_we_n,
    output logic [BLK_W-1:0] block_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, LI_FS, LI_CT, CC_A, CC_B, LO_CS, LO_WS, DONE
    } state_t;

    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLOCKS - 1);

    // pending/done/start vectors are ordered {FS, CT, CS, WS}
    localparam logic [3:0] P_FS   = 4'b1000;
    localparam logic [3:0] P_CT   = 4'b0100;
    localparam logic [3:0] P_CS   = 4'b0010;
    localparam logic [3:0] P_WS   = 4'b0001;

    state_t           state;
    logic [3:0]       pend;
    logic [3:0]       pend_eff;
    logic [3:0]       done_vec;
    logic [3:0]       start_vec;
    logic             phase_clear;
    logic [BLK_W-1:0] next_blk;

    // A done level seen while the matching start is still high is left over from the previous job.
    always_comb begin
        done_vec    = {FS_done, CT_done, CS_done, WS_done};
        start_vec   = {FS_start, CT_start, CS_start, WS_start};
        pend_eff    = pend & ~(done_vec & ~start_vec);
        phase_clear = (pend_eff == 4'b0000);
        next_blk    = block_count + BLK_W'(1);
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state       <= IDLE;
            block_count <= '0;
            pend        <= 4'b0000;
            FS_start    <= 1'b0;
            CT_start    <= 1'b0;
            CS_start    <= 1'b0;
            WS_start    <= 1'b0;
            M2_done     <= 1'b0;
        end else begin
            FS_start <= 1'b0;
            CT_start <= 1'b0;
            CS_start <= 1'b0;
            WS_start <= 1'b0;
            M2_done  <= 1'b0;
            pend     <= pend_eff;
            case (state)
                IDLE: if (M2_start) begin
                    state    <= LI_FS;
                    FS_start <= 1'b1;
                    pend     <= P_FS;
                end
                LI_FS: if (phase_clear) begin
                    state       <= LI_CT;
                    CT_start    <= 1'b1;
                    pend        <= P_CT;
                    block_count <= '0;
                end
                LI_CT: if (phase_clear) begin
                    CS_start <= 1'b1;
                    if (NUM_BLOCKS > 1) begin
                        state    <= CC_A;
                        FS_start <= 1'b1;
                        pend     <= P_CS | P_FS;
                    end else begin
                        state <= LO_CS;
                        pend  <= P_CS;
                    end
                end
                CC_A: if (phase_clear) begin
                    state    <= CC_B;
                    CT_start <= 1'b1;
                    WS_start <= 1'b1;
                    pend     <= P_CT | P_WS;
                end
                CC_B: if (phase_clear) begin
                    block_count <= next_blk;
                    CS_start    <= 1'b1;
                    if (next_blk == LAST_BLK) begin
                        state <= LO_CS;
                        pend  <= P_CS;
                    end else begin
                        state    <= CC_A;
                        FS_start <= 1'b1;
                        pend     <= P_CS | P_FS;
                    end
                end
                LO_CS: if (phase_clear) begin
                    state    <= LO_WS;
                    WS_start <= 1'b1;
                    pend     <= P_WS;
                end
                LO_WS: if (phase_clear) begin
                    state   <= DONE;
                    M2_done <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    block_count <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // FS phases only read; the WS write strobe reaches the SRAM only during WS phases.
    always_comb begin
        SRAM_address    = 18'h0;
        SRAM_write_data = 16'h0;
        SRAM_we_n       = 1'b1;
        case (state)
            LI_FS, CC_A: SRAM_address = FS_SRAM_address;
            CC_B, LO_WS: begin
                SRAM_address    = WS_SRAM_address;
                SRAM_write_data = WS_SRAM_write_data;
                SRAM_we_n       = WS_SRAM_we_n;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_m2_scheduler.sv
// Bench for m2_scheduler: phase-list reference model checked every cycle on a 3-block
// instance, plus a 1-block instance checked for start order and completion.
module tb_m2_scheduler;
    localparam int NB = 3;
    localparam int BW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, m2_start, m2_start1;
    logic [3:0]    dn, dn1, st, st1;
    logic [17:0]   fs_addr, ws_addr, sram_addr, sram_addr1;
    logic [15:0]   ws_data, sram_data, sram_data1;
    logic          ws_we_n, sram_we_n, sram_we_n1;
    logic          m2_done, m2_done1, busy, busy1;
    logic [BW-1:0] bc;
    logic [0:0]    bc1;

    m2_scheduler #(.NUM_BLOCKS(NB), .BLK_W(BW)) dut (
        .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2_start), .M2_done(m2_done),
        .FS_start(st[3]), .CT_start(st[2]), .CS_start(st[1]), .WS_start(st[0]),
        .FS_done(dn[3]), .CT_done(dn[2]), .CS_done(dn[1]), .WS_done(dn[0]),
        .FS_SRAM_address(fs_addr), .WS_SRAM_address(ws_addr),
        .WS_SRAM_write_data(ws_data), .WS_SRAM_we_n(ws_we_n),
        .SRAM_address(sram_addr), .SRAM_write_data(sram_data), .SRAM_we_n(sram_we_n),
        .block_count(bc), .busy(busy)
    );

    m2_scheduler #(.NUM_BLOCKS(1), .BLK_W(1)) dut1 (
        .CLOCK_50_I(clk), .Reset(rst), .M2_start(m2_start1), .M2_done(m2_done1),
        .FS_start(st1[3]), .CT_start(st1[2]), .CS_start(st1[1]), .WS_start(st1[0]),
        .FS_done(dn1[3]), .CT_done(dn1[2]), .CS_done(dn1[1]), .WS_done(dn1[0]),
        .FS_SRAM_address(18'h0), .WS_SRAM_address(18'h0),
        .WS_SRAM_write_data(16'h0), .WS_SRAM_we_n(1'b1),
        .SRAM_address(sram_addr1), .SRAM_write_data(sram_data1), .SRAM_we_n(sram_we_n1),
        .block_count(bc1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model: the pass as an ordered list of phases (units started, block index, SRAM owner)
    int ph_units[0:31];
    int ph_bc[0:31];
    int ph_mux[0:31];
    int n_ph, done_ph, ph;
    bit first;
    logic [3:0] outst;

    int  lat[4];
    int  cnt[4], cnt1[4];
    bit  act[4], act1[4];
    bit  fixmode, rnd_lat, spur;
    int  pcount[4];
    int  mdone_cnt, done_cyc, cca_cyc, ccb_cyc, bcmax, lifs;
    int  order[$];
    int  multi1, done1_cnt, done1_cyc, wsd1_cyc, lifs1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, a, e, cycle);
        end
    endtask

    task automatic add_ph(input int m, input int b, input int x);
        ph_units[n_ph] = m;
        ph_bc[n_ph]    = b;
        ph_mux[n_ph]   = x;
        n_ph++;
    endtask

    task automatic build_phases();
        n_ph = 0;
        add_ph(8, 0, 1);
        add_ph(4, 0, 0);
        for (int k = 0; k < NB - 1; k++) begin
            add_ph(10, k, 1);
            add_ph(5, k, 2);
        end
        add_ph(2, NB - 1, 0);
        add_ph(1, NB - 1, 2);
        done_ph = n_ph;
        add_ph(0, NB - 1, 0);
    endtask

    task automatic check();
        logic [3:0]  es;
        logic [17:0] ea;
        logic [15:0] ed;
        logic        ew;
        int          mux;
        es  = (ph >= 0 && first) ? 4'(ph_units[ph]) : 4'b0;
        mux = (ph >= 0) ? ph_mux[ph] : 0;
        ea  = (mux == 1) ? fs_addr : (mux == 2) ? ws_addr : 18'h0;
        ed  = (mux == 2) ? ws_data : 16'h0;
        ew  = (mux == 2) ? ws_we_n : 1'b1;
        chk("starts", st, es);
        chk("m2_done", m2_done, (ph == done_ph));
        chk("busy", busy, (ph >= 0));
        chk("block_count", bc, (ph >= 0) ? ph_bc[ph] : 0);
        chk("sram", {sram_addr, sram_data, sram_we_n}, {ea, ed, ew});
        if (fixmode && ph == 2 && first) begin
            chk("cca_addr", sram_addr, 18'h0ABCD);
            chk("cca_we_n", sram_we_n, 1'b1);
        end
        if (fixmode && ph == 3 && first) begin
            chk("ccb_addr", sram_addr, 18'h12345);
            chk("ccb_data", sram_data, 16'hBEEF);
            chk("ccb_we_n", sram_we_n, 1'b0);
        end
        for (int u = 0; u < 4; u++) if (st[u]) pcount[u]++;
        if (m2_done) begin mdone_cnt++; done_cyc = cycle; end
        if (busy && int'(bc) > bcmax) bcmax = int'(bc);
        if (st == 4'b1010) cca_cyc = cycle;
        if (st == 4'b0101) ccb_cyc = cycle;
        if (st1 != 4'b0) begin
            for (int u = 3; u >= 0; u--) if (st1[u]) order.push_back(u);
            if ($countones(st1) > 1) multi1++;
        end
        if (m2_done1) begin done1_cnt++; done1_cyc = cycle; end
    endtask

    // Sub-unit stand-ins: done stays at its old level through the start cycle, then drops until latency expires.
    task automatic bfm_step();
        for (int u = 0; u < 4; u++) begin
            if (st[u]) begin
                act[u] = 1'b1;
                cnt[u] = rnd_lat ? int'($urandom_range(1, 12)) : lat[u];
            end else if (act[u]) begin
                if (cnt[u] > 1) begin dn[u] = 1'b0; cnt[u]--; end
                else begin dn[u] = 1'b1; act[u] = 1'b0; end
            end
            if (st1[u]) begin
                act1[u] = 1'b1;
                cnt1[u] = 5;
            end else if (act1[u]) begin
                if (cnt1[u] > 1) begin dn1[u] = 1'b0; cnt1[u]--; end
                else begin
                    dn1[u] = 1'b1; act1[u] = 1'b0;
                    if (u == 0) wsd1_cyc = cycle;
                end
            end
        end
    endtask

    task automatic drive();
        if (fixmode) begin
            fs_addr = 18'h0ABCD; ws_addr = 18'h12345; ws_data = 16'hBEEF; ws_we_n = 1'b0;
        end else begin
            fs_addr = 18'($urandom); ws_addr = 18'($urandom);
            ws_data = 16'($urandom); ws_we_n = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic model_step();
        if (rst) begin
            ph = -1; first = 1'b0;
        end else if (ph < 0) begin
            if (m2_start) begin ph = 0; first = 1'b1; outst = 4'(ph_units[0]); end
        end else if (ph == done_ph) begin
            ph = -1; first = 1'b0;
        end else begin
            if (!first) outst = outst & ~dn;
            if (outst == 4'b0) begin
                ph++; first = 1'b1; outst = 4'(ph_units[ph]);
            end else begin
                first = 1'b0;
            end
        end
    endtask

    task automatic cyc();
        bfm_step();
        drive();
        model_step();
        @(negedge clk);
        cycle++;
        check();
    endtask

    task automatic run_pass(input int budget);
        int n;
        for (int u = 0; u < 4; u++) pcount[u] = 0;
        mdone_cnt = 0; bcmax = 0;
        m2_start = 1'b1; cyc(); m2_start = 1'b0;
        lifs = cycle;
        n = 0;
        while (ph >= 0 && n < budget) begin
            m2_start = spur && ph == 2 && first;
            cyc();
            m2_start = 1'b0;
            n++;
        end
        chk("pass_end_in_budget", (ph < 0), 1'b1);
        for (int u = 0; u < 4; u++) chk("pulse_count", pcount[u], NB);
        chk("m2_done_count", mdone_cnt, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; m2_start = 1'b0; m2_start1 = 1'b0;
        dn = 4'hF; dn1 = 4'h0;
        fixmode = 1'b0; rnd_lat = 1'b0; spur = 1'b0;
        for (int u = 0; u < 4; u++) begin lat[u] = 5; cnt[u] = 0; cnt1[u] = 0; act[u] = 1'b0; act1[u] = 1'b0; end
        ph = -1; first = 1'b0; outst = 4'b0;
        multi1 = 0; done1_cnt = 0; done1_cyc = 0; wsd1_cyc = 0;
        cca_cyc = 0; ccb_cyc = 0; done_cyc = 0;
        build_phases();
        drive();
        @(negedge clk);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();
        chk("reset_busy", busy, 1'b0);
        chk("reset_we_n", sram_we_n, 1'b1);
        chk("reset_bc", bc, 0);

        // fixed latency 5: eight 6-cycle phases, DONE 48 cycles after LI_FS
        run_pass(400);
        chk("pass_len_l5", done_cyc - lifs, 48);
        chk("bc_max", bcmax, NB - 1);

        // single-block instance
        m2_start1 = 1'b1; cyc(); m2_start1 = 1'b0;
        lifs1 = cycle;
        n = 0;
        while (busy1 && n < 100) begin cyc(); n++; end
        chk("u1_finished", busy1, 1'b0);
        chk("u1_order_len", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("u1_order", order[i], 3 - i);
        chk("u1_coincident", multi1, 0);
        chk("u1_done_count", done1_cnt, 1);
        chk("u1_pass_len", done1_cyc - lifs1, 24);
        chk("u1_done_after_ws", done1_cyc, wsd1_cyc + 1);
        chk("u1_idle_outputs", {sram_addr1, sram_data1, sram_we_n1, bc1}, {34'h0, 1'b1, 1'b0});

        // stale FS done and slow CS in CC_A
        lat[3] = 10; lat[2] = 3; lat[1] = 50; lat[0] = 3;
        run_pass(2000);
        chk("cc_a_len", ccb_cyc - cca_cyc, 51);

        // fixed SRAM inputs for mux pass-through / blocking
        for (int u = 0; u < 4; u++) lat[u] = 4;
        fixmode = 1'b1;
        run_pass(1000);
        fixmode = 1'b0;

        // random latencies with stray M2_start in CC_A
        rnd_lat = 1'b1; spur = 1'b1;
        repeat (3) run_pass(2000);
        spur = 1'b0;

        // reset in the middle of CC_B
        m2_start = 1'b1; cyc(); m2_start = 1'b0;
        n = 0;
        while (!(ph == 3 && !first) && n < 500) begin cyc(); n++; end
        chk("reached_cc_b", ph, 3);
        rst = 1'b1;
        cyc();
        chk("rst_starts", st, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_bc", bc, 0);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_m2_done", m2_done, 1'b0);
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        run_pass(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
